// File: rtl/keypad_pkg.sv
// Shared types and lookup helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } key_cls_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } key_state_e;

  // Pmod KYPD legend: row0 "123A", row1 "456B", row2 "789C", row3 "0FED".
  function automatic logic [3:0] key_code_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Frame-level debouncer: a classification must repeat for DEBOUNCE_SCANS frames before it is accepted.
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_valid_i,
  input  key_cls_e   cls_i,
  input  logic [3:0] code_i,
  output logic       accept_o,
  output key_cls_e   acc_cls_o,
  output logic [3:0] acc_code_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  key_cls_e      cand_cls_q;
  logic [3:0]    cand_code_q;
  logic [CW-1:0] cnt_q;
  logic          accept_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cand_cls_q  <= CLS_NONE;
      cand_code_q <= '0;
      cnt_q       <= '0;
      accept_q    <= 1'b0;
    end else begin
      accept_q <= 1'b0;
      if (frame_valid_i) begin
        if (cls_i == cand_cls_q && code_i == cand_code_q) begin
          // Saturating count means acceptance fires only once per candidate.
          if (cnt_q != CNT_MAX) begin
            cnt_q    <= cnt_q + CW'(1);
            accept_q <= (cnt_q + CW'(1)) == CNT_MAX;
          end
        end else begin
          cand_cls_q  <= cls_i;
          cand_code_q <= code_i;
          cnt_q       <= CW'(1);
          accept_q    <= (DEBOUNCE_SCANS == 1);
        end
      end
    end
  end

  assign accept_o   = accept_q;
  assign acc_cls_o  = cand_cls_q;
  assign acc_code_o = cand_code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, row synchronizer, frame classification and key-event FSM.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    row_meta_q, row_sync_q;
  logic [DW-1:0] div_q;
  logic [1:0]    col_idx_q;
  logic [3:0]    col_q;
  logic [15:0]   frame_q, frame_d;
  logic          col_last, frame_end;
  key_cls_e      cls;
  logic [3:0]    cls_code;
  logic          accept;
  key_cls_e      acc_cls;
  logic [3:0]    acc_code;
  key_state_e    state_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q, key_held_q;

  assign col_last  = (div_q == DIV_LAST);
  assign frame_end = col_last && (col_idx_q == 2'd3);

  // Frame bit c*4+r is high when key (r,c) is down; current column merged in so the
  // frame can be classified on the same edge that samples column 3.
  always_comb begin
    frame_d = frame_q;
    frame_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
  end

  always_comb begin
    logic [4:0] n;
    logic [3:0] code;
    n    = '0;
    code = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        if (frame_d[c*NUM_ROWS + r]) begin
          n    = n + 5'd1;
          code = key_code_of(r[1:0], c[1:0]);
        end
      end
    end
    cls      = (n == 5'd0) ? CLS_NONE : (n == 5'd1) ? CLS_SINGLE : CLS_MULTI;
    cls_code = (n == 5'd1) ? code : 4'h0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      div_q      <= '0;
      col_idx_q  <= '0;
      col_q      <= 4'b1110;
      frame_q    <= '0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      if (col_last) begin
        div_q     <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        col_q     <= col_drive(col_idx_q + 2'd1);
        frame_q   <= frame_d;
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

  keypad_frame_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_i        (clock),
    .rst_i        (reset),
    .frame_valid_i(frame_end),
    .cls_i        (cls),
    .code_i       (cls_code),
    .accept_o     (accept),
    .acc_cls_o    (acc_cls),
    .acc_code_o   (acc_code)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (accept) begin
        case (acc_cls)
          CLS_SINGLE: begin
            if (state_q == ST_IDLE || acc_code != key_code_q) begin
              state_q     <= ST_PRESSED;
              key_code_q  <= acc_code;
              key_held_q  <= 1'b1;
              key_valid_q <= 1'b1;
            end
          end
          CLS_NONE: begin
            if (state_q == ST_PRESSED) begin
              state_q    <= ST_IDLE;
              key_held_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart to the multiplexed seven-segment display driver. It drives a 4x4 matrix keypad (Pmod KYPD) one column at a time and reads the rows back. It debounces complete scan frames and emits a one-cycle key event with a 4-bit code. Its outputs feed the stopwatch control path, for example as start/reset/digit-entry strobes, in place of raw switch levels.

Parameters:
SCAN_DIV, 100000, clock cycles each column is driven (1 ms at 100 MHz); minimum 4
DEBOUNCE_SCANS, 4, consecutive identical frames required before a frame classification is accepted; minimum 1

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
col  output  4  column drive, active-low, exactly one bit low at all times
row  input  4  row sense, active-low, externally pulled up, asynchronous
key_code  output  4  code of the last accepted key
key_valid  output  1  one-cycle pulse when a new key is accepted
key_held  output  1  high while an accepted key remains pressed

Behaviour:
- Interface fixed: one clock, `clock`; reset `reset` is asynchronous and active-high.
- Reset values:
  - col=4'b1110
  - key_code=0, key_valid=0, key_held=0
  - row synchronizer=4'b1111
  - all counters 0
  - debounce candidate=NONE
  - accepted state=IDLE
- Row input: 2-flop synchronizer before any use.
- Column scan:
  - div counter 0..SCAN_DIV-1.
  - Rows are sampled when div==SCAN_DIV-1, the last cycle of the column period, which allows settling plus synchronizer delay.
  - On the next cycle the column index advances 0→1→2→3→0, and col rotates the low bit: 1110→1101→1011→0111→1110.
- Frame:
  - 16 bits = 4 columns × 4 rows of sampled data.
  - A frame completes when column 3 is sampled; frame period = 4·SCAN_DIV cycles.
- Classification at frame end:
  - NONE if 0 keys are down.
  - SINGLE(k) if exactly 1 key is down, with k = the code of (row r, col c).
  - MULTI if 2 or more keys are down.
- Code map (row0..3 × col0..3):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Debounce:
  - If the classification equals the candidate, increment the match count, saturating at DEBOUNCE_SCANS.
  - Otherwise set candidate = classification and match count = 1.
  - The candidate is accepted on the frame where the count reaches DEBOUNCE_SCANS. Acceptance fires once per change of candidate.
- Accepted-state FSM, IDLE / PRESSED(k):
  - IDLE + accepted SINGLE(k) → PRESSED(k): key_code=k, key_held=1, key_valid=1 for the single cycle after frame end.
  - PRESSED(k) + accepted NONE → IDLE: key_held=0, no pulse, key_code retained.
  - PRESSED(k) + accepted SINGLE(j≠k) → PRESSED(j): key_code=j, key_valid pulse, key_held stays 1.
  - PRESSED(k) + accepted SINGLE(k): no action.
  - Any state + accepted MULTI: no change, no pulse (ghosting rejected).
- Latency: first pulse occurs between (DEBOUNCE_SCANS−1)·frame+1 and DEBOUNCE_SCANS·frame+2 cycles after the row settles.
- Reset mid-operation: immediate return to reset values. A key held across reset is re-accepted after DEBOUNCE_SCANS full frames, with a fresh pulse.
- Widths: div counter is $clog2(SCAN_DIV) bits; match counter is $clog2(DEBOUNCE_SCANS+1) bits.

Decomposition:
- Package keypad_pkg:
  - NUM_ROWS=4, NUM_COLS=4
  - key-class enum {CLS_NONE, CLS_SINGLE, CLS_MULTI}
  - 16-entry code table constant/function (row, col → 4-bit code)
  - column drive patterns
- Sub-module keypad_frame_debounce:
  - takes the frame-valid strobe plus classification/code
  - outputs the accept strobe plus accepted class/code
- Scanner top holds the synchronizer, divider, column rotation and accepted-state FSM.

Test Plan:
Bench settings: SCAN_DIV=4, DEBOUNCE_SCANS=3. Rows are modelled combinationally from col.
1. Reset checks: assert reset mid-run → col=1110 and outputs 0 in the same cycle. Release → col steps 1110,1101,1011,0111 every 4 cycles.
2. Single key: hold key '5' (row1/col1) for 6 frames → exactly one key_valid pulse with key_code=5 within 3 frames, then key_held=1. Release → key_held=0 within 3 frames, no pulse, key_code stays 5.
3. Bounce: toggle row for key '9' every 5 cycles for 2 frames, then hold steady → exactly one pulse, code=9.
4. Ghosting: press '1'+'2' together from IDLE → no pulse, key_held=0. Hold '1' until accepted, then add '2' → key_held=1, code stays 1, no extra pulse.
5. Roll-over: hold 'A', then switch directly to 'D' without a NONE gap → second pulse with code=4'hD, key_held never drops.
6. Reset while key '0' held: outputs cleared. After reset release → new pulse with code=0 after 3 frames.
